// File: rtl/wb_pkg.sv
// Shared defaults and types for the writeback commit queue.
// REG_ZERO is the hard-wired x0 index; results targeting it are dropped.
package wb_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_mem.sv
// Circular storage for pending writeback results.
// Every entry is exposed with a valid bit so the top level can run a bypass search.
module wb_queue_mem
  import wb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_rd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_head_rd,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CW-1:0]     o_count,
  output logic [PW-1:0]     o_tail,
  output logic [DEPTH-1:0]  o_valid,
  output logic [ADDR_W-1:0] o_ent_rd   [DEPTH],
  output logic [DATA_W-1:0] o_ent_data [DEPTH]
);

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [CW-1:0]     w_count_next;
  logic [DEPTH-1:0]  w_valid_next;

  // Payload storage needs no reset: the valid bits gate every read.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_rd[r_tail]   <= i_push_rd;
      r_data[r_tail] <= i_push_data;
    end
  end

  always_comb begin
    w_count_next = r_count;
    w_valid_next = r_valid;
    case ({i_push, i_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
    if (i_pop) begin
      w_valid_next[r_head] = 1'b0;
    end
    if (i_push) begin
      w_valid_next[r_tail] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= w_count_next;
      r_valid <= w_valid_next;
    end
  end

  assign o_head_rd   = r_rd[r_head];
  assign o_head_data = r_data[r_head];
  assign o_count     = r_count;
  assign o_tail      = r_tail;
  assign o_valid     = r_valid;
  assign o_ent_rd    = r_rd;
  assign o_ent_data  = r_data;

endmodule

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers completed results and drains one register-file write per cycle.
// Decode lookups see queued values and the in-flight RF write, newest first.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [ADDR_W-1:0] i_in_rd,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_rf_hold,
  output logic              o_rf_write_en,
  output logic [ADDR_W-1:0] o_rf_add_dest,
  output logic [DATA_W-1:0] o_rf_write_data,
  input  logic [ADDR_W-1:0] i_look_a,
  input  logic [ADDR_W-1:0] i_look_b,
  output logic              o_hit_a,
  output logic              o_hit_b,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b,
  output logic [CW-1:0]     o_count,
  output logic              o_empty
);

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [CW-1:0]     w_count;
  logic [PW-1:0]     w_tail;
  logic [DEPTH-1:0]  w_valid;
  logic [ADDR_W-1:0] w_ent_rd   [DEPTH];
  logic [DATA_W-1:0] w_ent_data [DEPTH];

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_rd;
  logic [DATA_W-1:0] r_rf_data;

  logic [1:0][ADDR_W-1:0] w_look;
  logic [1:0]             w_hit;
  logic [1:0][DATA_W-1:0] w_hdata;

  // Ready looks only at occupancy, so a full queue stays closed through a draining edge.
  assign o_in_ready = (w_count < CW'(DEPTH));
  assign w_push     = i_in_valid && o_in_ready && (i_in_rd != ADDR_W'(REG_ZERO));
  assign w_pop      = (w_count != '0) && !i_rf_hold;

  wb_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_rd   (i_in_rd),
    .i_push_data (i_in_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_tail      (w_tail),
    .o_valid     (w_valid),
    .o_ent_rd    (w_ent_rd),
    .o_ent_data  (w_ent_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
    end else if (w_pop) begin
      r_rf_we   <= 1'b1;
      r_rf_rd   <= w_head_rd;
      r_rf_data <= w_head_data;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  assign w_look = {i_look_b, i_look_a};

  // The RF register has lowest priority: the register file still returns the old value while it is written.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
      logic              w_hit_g;
      logic [DATA_W-1:0] w_data_g;
      logic [PW-1:0]     w_idx_g;

      always_comb begin
        w_hit_g  = 1'b0;
        w_data_g = '0;
        w_idx_g  = '0;
        if (w_look[gi] != ADDR_W'(REG_ZERO)) begin
          if (r_rf_we && (r_rf_rd == w_look[gi])) begin
            w_hit_g  = 1'b1;
            w_data_g = r_rf_data;
          end
          for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx_g = w_tail - PW'(1) - k[PW-1:0];
            if (w_valid[w_idx_g] && (w_ent_rd[w_idx_g] == w_look[gi])) begin
              w_hit_g  = 1'b1;
              w_data_g = w_ent_data[w_idx_g];
            end
          end
        end
      end

      assign w_hit[gi]   = w_hit_g;
      assign w_hdata[gi] = w_data_g;
    end
  endgenerate

  assign o_rf_write_en   = r_rf_we;
  assign o_rf_add_dest   = r_rf_rd;
  assign o_rf_write_data = r_rf_data;
  assign o_hit_a         = w_hit[0];
  assign o_hit_b         = w_hit[1];
  assign o_data_a        = w_hdata[0];
  assign o_data_b        = w_hdata[1];
  assign o_count         = w_count;
  assign o_empty         = (w_count == '0) && !r_rf_we;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed vector table, mid-drain reset, and a randomised
// hold sequence, all backed by a write scoreboard and an occupancy model.
module tb_wb_commit_queue;
  import wb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CW     = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              rf_hold;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic [ADDR_W-1:0] look_a;
  logic [ADDR_W-1:0] look_b;
  logic              hit_a;
  logic              hit_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [CW-1:0]     count;
  logic              empty;

  int        n_checks = 0;
  int        n_errors = 0;
  bit        mon_en   = 1'b0;
  int        m_cnt    = 0;
  bit        m_we     = 1'b0;
  int        n_acc    = 0;
  wb_entry_t sb[$];

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        hold;
    logic [4:0]  look;
    logic        we;
    logic [4:0]  erd;
    logic [31:0] edata;
    int          cnt;
    logic        rdy;
    logic        emp;
    logic        hit;
    logic [31:0] hdata;
  } vec_t;

  vec_t vt [21];

  wb_commit_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_rd         (in_rd),
    .i_in_data       (in_data),
    .i_rf_hold       (rf_hold),
    .o_rf_write_en   (rf_we),
    .o_rf_add_dest   (rf_rd),
    .o_rf_write_data (rf_data),
    .i_look_a        (look_a),
    .i_look_b        (look_b),
    .o_hit_a         (hit_a),
    .o_hit_b         (hit_b),
    .o_data_a        (data_a),
    .o_data_b        (data_b),
    .o_count         (count),
    .o_empty         (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [31:0] d, logic h, logic [4:0] lk,
                              logic we, logic [4:0] erd, logic [31:0] ed, int cnt,
                              logic rdy, logic emp, logic hit, logic [31:0] hd);
    vec_t r;
    r.v = v; r.rd = rd; r.data = d; r.hold = h; r.look = lk;
    r.we = we; r.erd = erd; r.edata = ed; r.cnt = cnt;
    r.rdy = rdy; r.emp = emp; r.hit = hit; r.hdata = hd;
    return r;
  endfunction

  // Occupancy model and scoreboard feed, evaluated on the same edges as the DUT.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0;
      m_we  = 1'b0;
      sb.delete();
    end else begin
      bit pop;
      bit push;
      pop  = (m_cnt > 0) && !rf_hold;
      push = in_valid && (m_cnt < DEPTH) && (in_rd != 5'd0);
      m_we  = pop;
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (push) begin
        sb.push_back('{rd: in_rd, data: in_data});
        n_acc++;
      end
    end
  end

  // Monitor: every RF write must match the oldest outstanding accepted result.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("mon_write_en", rf_we, m_we);
      check("mon_count", count, m_cnt);
      check("mon_in_ready", in_ready, m_cnt < DEPTH);
      check("mon_empty", empty, (m_cnt == 0) && !m_we);
      if (rf_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got write rd=%0d data=%0h expected no write", rf_rd, rf_data);
        end else begin
          wb_entry_t e;
          e = sb.pop_front();
          check("sb_rd", rf_rd, e.rd);
          check("sb_data", rf_data, e.data);
          $display("write rd=%0d data=%08h", rf_rd, rf_data);
        end
      end
    end
  end

  initial begin
    int target;
    int last;

    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
    rf_hold = 1'b0; look_a = '0; look_b = '0;

    //                v  rd     data   hold look  we erd   edata        cnt rdy emp hit hdata
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 5,  0, 0, 32'h0,        1, 1, 0, 1, 32'hDEADBEEF);
    vt[1]  = mk(0, 0, 32'h0,        0, 5,  1, 5, 32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF);
    vt[2]  = mk(0, 0, 32'h0,        0, 5,  0, 5, 32'hDEADBEEF, 0, 1, 1, 0, 32'h0);
    vt[3]  = mk(1, 0, 32'h1234,     0, 0,  0, 5, 32'hDEADBEEF, 0, 1, 1, 0, 32'h0);
    vt[4]  = mk(0, 0, 32'h0,        0, 0,  0, 5, 32'hDEADBEEF, 0, 1, 1, 0, 32'h0);
    vt[5]  = mk(1, 1, 32'h10,       1, 1,  0, 5, 32'hDEADBEEF, 1, 1, 0, 1, 32'h10);
    vt[6]  = mk(1, 2, 32'h20,       1, 1,  0, 5, 32'hDEADBEEF, 2, 1, 0, 1, 32'h10);
    vt[7]  = mk(1, 3, 32'h30,       1, 1,  0, 5, 32'hDEADBEEF, 3, 1, 0, 1, 32'h10);
    vt[8]  = mk(1, 4, 32'h40,       1, 4,  0, 5, 32'hDEADBEEF, 4, 0, 0, 1, 32'h40);
    vt[9]  = mk(1, 5, 32'h50,       1, 5,  0, 5, 32'hDEADBEEF, 4, 0, 0, 0, 32'h0);
    vt[10] = mk(1, 5, 32'h50,       0, 5,  1, 1, 32'h10,       3, 1, 0, 0, 32'h0);
    vt[11] = mk(1, 5, 32'h50,       0, 5,  1, 2, 32'h20,       3, 1, 0, 1, 32'h50);
    vt[12] = mk(0, 0, 32'h0,        0, 5,  1, 3, 32'h30,       2, 1, 0, 1, 32'h50);
    vt[13] = mk(0, 0, 32'h0,        0, 5,  1, 4, 32'h40,       1, 1, 0, 1, 32'h50);
    vt[14] = mk(0, 0, 32'h0,        0, 5,  1, 5, 32'h50,       0, 1, 0, 1, 32'h50);
    vt[15] = mk(0, 0, 32'h0,        0, 5,  0, 5, 32'h50,       0, 1, 1, 0, 32'h0);
    vt[16] = mk(1, 7, 32'h11,       1, 7,  0, 5, 32'h50,       1, 1, 0, 1, 32'h11);
    vt[17] = mk(1, 7, 32'h22,       1, 7,  0, 5, 32'h50,       2, 1, 0, 1, 32'h22);
    vt[18] = mk(0, 0, 32'h0,        0, 7,  1, 7, 32'h11,       1, 1, 0, 1, 32'h22);
    vt[19] = mk(0, 0, 32'h0,        0, 7,  1, 7, 32'h22,       0, 1, 0, 1, 32'h22);
    vt[20] = mk(0, 0, 32'h0,        0, 7,  0, 7, 32'h22,       0, 1, 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    check("reset_write_en", rf_we, 1'b0);
    check("reset_add_dest", rf_rd, 5'd0);
    check("reset_write_data", rf_data, 32'd0);
    check("reset_count", count, 3'd0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_empty", empty, 1'b1);
    check("reset_hit_a", hit_a, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 21; i++) begin
      in_valid = vt[i].v;
      in_rd    = vt[i].rd;
      in_data  = vt[i].data;
      rf_hold  = vt[i].hold;
      look_a   = vt[i].look;
      look_b   = vt[i].look;
      @(negedge clk);
      check($sformatf("v%0d_write_en", i), rf_we, vt[i].we);
      check($sformatf("v%0d_add_dest", i), rf_rd, vt[i].erd);
      check($sformatf("v%0d_write_data", i), rf_data, vt[i].edata);
      check($sformatf("v%0d_count", i), count, vt[i].cnt);
      check($sformatf("v%0d_in_ready", i), in_ready, vt[i].rdy);
      check($sformatf("v%0d_empty", i), empty, vt[i].emp);
      check($sformatf("v%0d_hit_a", i), hit_a, vt[i].hit);
      check($sformatf("v%0d_data_a", i), data_a, vt[i].hdata);
      check($sformatf("v%0d_hit_b", i), hit_b, vt[i].hit);
      check($sformatf("v%0d_data_b", i), data_b, vt[i].hdata);
      $display("vector %0d: we=%0b rd=%0d data=%08h count=%0d hit=%0b", i, rf_we, rf_rd, rf_data, count, hit_a);
    end

    // Reset in the middle of a drain: three entries queued and a write in flight.
    rf_hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_rd   = 5'(9 + i);
      in_data = 32'hA0 + i;
      @(negedge clk);
    end
    in_valid = 1'b0; rf_hold = 1'b0;
    @(negedge clk);
    check("middrain_count", count, 3'd3);
    check("middrain_write_en", rf_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_write_en", rf_we, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_empty", empty, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_add_dest", rf_rd, 5'd0);
    $display("reset mid-drain: we=%0b count=%0d empty=%0b", rf_we, count, empty);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_stale_%0d", i), rf_we, 1'b0);
    end

    // Randomised holds with back-to-back offers; each item is held until accepted.
    target   = n_acc + 20;
    last     = n_acc;
    in_valid = 1'b1;
    in_rd    = 5'($urandom_range(1, 31));
    in_data  = $urandom;
    rf_hold  = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 600 && n_acc < target; cyc++) begin
      @(negedge clk);
      rf_hold = 1'($urandom_range(0, 1));
      if (n_acc != last) begin
        last    = n_acc;
        in_rd   = 5'($urandom_range(1, 31));
        in_data = $urandom;
      end
    end
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    check("random_all_accepted", n_acc >= target, 1'b1);
    repeat (8) @(negedge clk);
    check("random_sb_drained", sb.size(), 0);
    check("random_final_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
